// File: rtl/dds_sweep_ctrl_if.sv
// Wishbone write-master bundle between dds_sweep_ctrl and the simple_dds slave port.
interface dds_sweep_ctrl_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] m_addr_o;
    logic [DATA_WIDTH-1:0] m_dat_o;
    logic                  m_we_o;
    logic                  m_stb_o;
    logic                  m_ack_i;

    modport master (
        output m_addr_o,
        output m_dat_o,
        output m_we_o,
        output m_stb_o,
        input  m_ack_i
    );

    modport slave (
        input  m_addr_o,
        input  m_dat_o,
        input  m_we_o,
        input  m_stb_o,
        output m_ack_i
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Wishbone master that programs simple_dds and steps its tuning word through a sweep.
// state | meaning
// IDLE  | waiting for start
// W_SRC | write source select (addr 2)
// W_GAIN| write gain (addr 4)
// W_OFS | write offset (addr 5)
// W_TW  | write tuning word (addr 3)
// W_EN  | enable output (addr 1, data 1), once per sweep
// DWELL | hold current tone for max(dwell,1) cycles
// NEXT  | choose next tuning word, reload, or finish
// W_DIS | disable output (addr 1, data 0), then IDLE
module dds_sweep_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int TW_WIDTH    = 8,
    parameter int DWELL_WIDTH = 16,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_n_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [1:0]             src_i,
    input  logic [1:0]             gain_i,
    input  logic [15:0]            offset_i,
    input  logic [TW_WIDTH-1:0]    tw_start_i,
    input  logic [TW_WIDTH-1:0]    tw_stop_i,
    input  logic [TW_WIDTH-1:0]    tw_step_i,
    input  logic [DWELL_WIDTH-1:0] dwell_i,
    input  logic                   loop_i,
    dds_sweep_ctrl_if.master       wb,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [TW_WIDTH-1:0]    cur_tw_o
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE,
        W_SRC,
        W_GAIN,
        W_OFS,
        W_TW,
        W_EN,
        DWELL,
        NEXT,
        W_DIS
    } state_t;

    state_t                  state_q, state_d;
    logic                    stb_q, stb_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [DWELL_WIDTH-1:0]  dwell_q, dwell_d;
    logic [TW_WIDTH-1:0]     tw_q, tw_d;
    logic [TW_WIDTH-1:0]     cur_tw_q, cur_tw_d;
    logic                    err_q, err_d;
    logic                    done_q, done_d;
    logic                    abort_q, abort_d;
    logic                    en_done_q, en_done_d;

    logic [1:0]              src_s;
    logic [1:0]              gain_s;
    logic [15:0]             ofs_s;
    logic [TW_WIDTH-1:0]     tw_start_s;
    logic [TW_WIDTH-1:0]     tw_stop_s;
    logic [TW_WIDTH-1:0]     step_s;
    logic [DWELL_WIDTH-1:0]  dwell_s;
    logic                    loop_s;

    logic                    load_cfg;
    logic                    abort_pend;
    logic                    wr_go;
    state_t                  wr_state;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_dat;
    logic                    dwell_go;
    logic [TW_WIDTH:0]       sum_w;

    // One extra bit so a wrap past the top of the tuning range reads as overflow.
    assign sum_w = {1'b0, tw_q} + {1'b0, step_s};

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            src_s      <= '0;
            gain_s     <= '0;
            ofs_s      <= '0;
            tw_start_s <= '0;
            tw_stop_s  <= '0;
            step_s     <= '0;
            dwell_s    <= '0;
            loop_s     <= 1'b0;
        end else if (load_cfg) begin
            src_s      <= src_i;
            gain_s     <= gain_i;
            ofs_s      <= offset_i;
            tw_start_s <= tw_start_i;
            tw_stop_s  <= tw_stop_i;
            step_s     <= tw_step_i;
            dwell_s    <= dwell_i;
            loop_s     <= loop_i;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= IDLE;
            stb_q     <= 1'b0;
            addr_q    <= '0;
            dat_q     <= '0;
            tmo_q     <= '0;
            dwell_q   <= '0;
            tw_q      <= '0;
            cur_tw_q  <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            en_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stb_q     <= stb_d;
            addr_q    <= addr_d;
            dat_q     <= dat_d;
            tmo_q     <= tmo_d;
            dwell_q   <= dwell_d;
            tw_q      <= tw_d;
            cur_tw_q  <= cur_tw_d;
            err_q     <= err_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            en_done_q <= en_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        stb_d      = stb_q;
        addr_d     = addr_q;
        dat_d      = dat_q;
        tmo_d      = tmo_q;
        dwell_d    = dwell_q;
        tw_d       = tw_q;
        cur_tw_d   = cur_tw_q;
        err_d      = err_q;
        done_d     = 1'b0;
        abort_d    = abort_q;
        en_done_d  = en_done_q;
        load_cfg   = 1'b0;
        wr_go      = 1'b0;
        wr_state   = state_q;
        wr_addr    = '0;
        wr_dat     = '0;
        dwell_go   = 1'b0;
        abort_pend = 1'b0;

        if (abort_i && state_q != IDLE && state_q != W_DIS) begin
            abort_d = 1'b1;
        end
        abort_pend = abort_d;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    load_cfg  = 1'b1;
                    err_d     = 1'b0;
                    abort_d   = 1'b0;
                    en_done_d = 1'b0;
                    tw_d      = tw_start_i;
                    wr_go     = 1'b1;
                    wr_state  = W_SRC;
                    wr_addr   = ADDR_WIDTH'(2);
                    wr_dat    = DATA_WIDTH'(src_i);
                end
            end
            W_SRC, W_GAIN, W_OFS, W_TW, W_EN, W_DIS: begin
                if (stb_q) begin
                    if (wb.m_ack_i) begin
                        stb_d = 1'b0;
                        if (state_q == W_TW) cur_tw_d = tw_q;
                        if (state_q == W_EN) en_done_d = 1'b1;
                    end else if (tmo_q == '0) begin
                        stb_d   = 1'b0;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        abort_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        tmo_d = tmo_q - TMO_W'(1);
                    end
                end else if (state_q == W_DIS) begin
                    // stb low here is the mandatory gap cycle after the last ack
                    state_d = IDLE;
                    done_d  = 1'b1;
                    abort_d = 1'b0;
                end else if (abort_pend) begin
                    wr_go    = 1'b1;
                    wr_state = W_DIS;
                    wr_addr  = ADDR_WIDTH'(1);
                    wr_dat   = '0;
                end else begin
                    case (state_q)
                        W_SRC: begin
                            wr_go    = 1'b1;
                            wr_state = W_GAIN;
                            wr_addr  = ADDR_WIDTH'(4);
                            wr_dat   = DATA_WIDTH'(gain_s);
                        end
                        W_GAIN: begin
                            wr_go    = 1'b1;
                            wr_state = W_OFS;
                            wr_addr  = ADDR_WIDTH'(5);
                            wr_dat   = DATA_WIDTH'(ofs_s);
                        end
                        W_OFS: begin
                            wr_go    = 1'b1;
                            wr_state = W_TW;
                            wr_addr  = ADDR_WIDTH'(3);
                            wr_dat   = DATA_WIDTH'(tw_q);
                        end
                        W_TW: begin
                            if (!en_done_q) begin
                                wr_go    = 1'b1;
                                wr_state = W_EN;
                                wr_addr  = ADDR_WIDTH'(1);
                                wr_dat   = DATA_WIDTH'(1);
                            end else begin
                                dwell_go = 1'b1;
                            end
                        end
                        default: dwell_go = 1'b1;
                    endcase
                end
            end
            DWELL: begin
                if (abort_pend) begin
                    wr_go    = 1'b1;
                    wr_state = W_DIS;
                    wr_addr  = ADDR_WIDTH'(1);
                    wr_dat   = '0;
                end else if (dwell_q == '0) begin
                    state_d = NEXT;
                end else begin
                    dwell_d = dwell_q - DWELL_WIDTH'(1);
                end
            end
            NEXT: begin
                if (abort_pend) begin
                    wr_go    = 1'b1;
                    wr_state = W_DIS;
                    wr_addr  = ADDR_WIDTH'(1);
                    wr_dat   = '0;
                end else if (step_s == '0) begin
                    dwell_go = 1'b1;
                end else if (sum_w <= {1'b0, tw_stop_s}) begin
                    tw_d     = sum_w[TW_WIDTH-1:0];
                    wr_go    = 1'b1;
                    wr_state = W_TW;
                    wr_addr  = ADDR_WIDTH'(3);
                    wr_dat   = DATA_WIDTH'(sum_w[TW_WIDTH-1:0]);
                end else if (loop_s) begin
                    tw_d     = tw_start_s;
                    wr_go    = 1'b1;
                    wr_state = W_TW;
                    wr_addr  = ADDR_WIDTH'(3);
                    wr_dat   = DATA_WIDTH'(tw_start_s);
                end else begin
                    wr_go    = 1'b1;
                    wr_state = W_DIS;
                    wr_addr  = ADDR_WIDTH'(1);
                    wr_dat   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // dwell of 0 behaves as 1: terminal count is reached on the first DWELL cycle
        if (dwell_go) begin
            state_d = DWELL;
            dwell_d = (dwell_s == '0) ? '0 : dwell_s - DWELL_WIDTH'(1);
        end

        if (wr_go) begin
            state_d = wr_state;
            stb_d   = 1'b1;
            addr_d  = wr_addr;
            dat_d   = wr_dat;
            tmo_d   = TMO_W'(ACK_TIMEOUT - 1);
        end
    end

    assign wb.m_addr_o = addr_q;
    assign wb.m_dat_o  = dat_q;
    assign wb.m_we_o   = stb_q;
    assign wb.m_stb_o  = stb_q;

    assign busy_o   = (state_q != IDLE);
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign cur_tw_o = cur_tw_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl against a registered-ack simple_dds slave model.
`timescale 1ns/1ps
module tb_dds_sweep_ctrl;

    logic        wb_clk_i   = 1'b0;
    logic        wb_rst_n_i = 1'b0;
    logic        start_i    = 1'b0;
    logic        abort_i    = 1'b0;
    logic [1:0]  src_i      = '0;
    logic [1:0]  gain_i     = '0;
    logic [15:0] offset_i   = '0;
    logic [7:0]  tw_start_i = '0;
    logic [7:0]  tw_stop_i  = '0;
    logic [7:0]  tw_step_i  = '0;
    logic [15:0] dwell_i    = '0;
    logic        loop_i     = 1'b0;
    logic        busy_o, done_o, err_o;
    logic [7:0]  cur_tw_o;
    logic        slave_en   = 1'b1;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int t0 = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int acc_cnt = 0;
    int stb_cycles = 0;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] dat;
        int          rel;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    dds_sweep_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

    dds_sweep_ctrl u_dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n_i (wb_rst_n_i),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .src_i      (src_i),
        .gain_i     (gain_i),
        .offset_i   (offset_i),
        .tw_start_i (tw_start_i),
        .tw_stop_i  (tw_stop_i),
        .tw_step_i  (tw_step_i),
        .dwell_i    (dwell_i),
        .loop_i     (loop_i),
        .wb         (bus),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .cur_tw_o   (cur_tw_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    always @(posedge wb_clk_i) cyc <= cyc + 1;

    // simple_dds-like slave: registered ack that echoes one stale cycle after stb drops
    always @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) bus.m_ack_i <= 1'b0;
        else             bus.m_ack_i <= slave_en & bus.m_stb_o;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge wb_clk_i) begin
        if (bus.m_stb_o) stb_cycles++;
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc - t0;
        end
        if (wb_rst_n_i && bus.m_stb_o && bus.m_ack_i) begin
            acc_cnt++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_write addr=%0h dat=%0h expected no write", bus.m_addr_o, bus.m_dat_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk("write_addr", 64'(bus.m_addr_o), 64'(mon_e.addr));
                chk("write_data", 64'(bus.m_dat_o), 64'(mon_e.dat));
                chk("write_we", 64'(bus.m_we_o), 64'd1);
                if (mon_e.rel >= 0) chk("write_cycle", 64'(cyc - t0), 64'(mon_e.rel));
            end
        end
    end

    task automatic push(input logic [15:0] a, input logic [31:0] d, input int rel);
        exp_t e;
        e.addr = a;
        e.dat  = d;
        e.rel  = rel;
        exp_q.push_back(e);
    endtask

    task automatic set_cfg(input logic [1:0] s, input logic [1:0] g, input logic [15:0] o,
                           input logic [7:0] ts, input logic [7:0] tp, input logic [7:0] st,
                           input logic [15:0] dw, input logic lp);
        src_i = s; gain_i = g; offset_i = o;
        tw_start_i = ts; tw_stop_i = tp; tw_step_i = st;
        dwell_i = dw; loop_i = lp;
    endtask

    task automatic do_start();
        @(negedge wb_clk_i);
        done_cnt   = 0;
        done_cyc   = -1;
        acc_cnt    = 0;
        stb_cycles = 0;
        start_i    = 1'b1;
        @(posedge wb_clk_i);
        #1;
        t0      = cyc;
        start_i = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge wb_clk_i);
        start_i = 1'b1;
        @(negedge wb_clk_i);
        start_i = 1'b0;
    endtask

    task automatic pulse_abort();
        @(negedge wb_clk_i);
        abort_i = 1'b1;
        @(negedge wb_clk_i);
        abort_i = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy_o && n < bound) begin
            @(negedge wb_clk_i);
            n++;
        end
        chk("idle_reached", 64'(busy_o), 64'd0);
        repeat (2) @(negedge wb_clk_i);
    endtask

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge wb_clk_i);
        chk("rst_stb", 64'(bus.m_stb_o), 64'd0);
        chk("rst_we", 64'(bus.m_we_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_cur_tw", 64'(cur_tw_o), 64'd0);
        wb_rst_n_i = 1'b1;
        repeat (2) @(negedge wb_clk_i);

        // basic sweep with exact cycle positions; config changed and start re-pulsed while busy
        set_cfg(2'd1, 2'd2, 16'h1234, 8'd10, 8'd40, 8'd10, 16'd4, 1'b0);
        push(16'd2, 32'd1, 1);
        push(16'd4, 32'd2, 4);
        push(16'd5, 32'h1234, 7);
        push(16'd3, 32'd10, 10);
        push(16'd1, 32'd1, 13);
        push(16'd3, 32'd20, 21);
        push(16'd3, 32'd30, 29);
        push(16'd3, 32'd40, 37);
        push(16'd1, 32'd0, 45);
        do_start();
        chk("start_stb_next_cycle", 64'(bus.m_stb_o), 64'd1);
        chk("start_busy", 64'(busy_o), 64'd1);
        tw_stop_i = 8'd200;
        src_i     = 2'd3;
        repeat (16) @(negedge wb_clk_i);
        pulse_start();
        wait_idle(200);
        chk("t1_done_count", 64'(done_cnt), 64'd1);
        chk("t1_done_cycle", 64'(done_cyc), 64'd47);
        chk("t1_cur_tw", 64'(cur_tw_o), 64'd40);
        chk("t1_err", 64'(err_o), 64'd0);
        chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);

        // looping sweep across the top of the range, aborted during a TW write
        set_cfg(2'd2, 2'd3, 16'hbeef, 8'd250, 8'd255, 8'd4, 16'd2, 1'b1);
        push(16'd2, 32'd2, -1);
        push(16'd4, 32'd3, -1);
        push(16'd5, 32'hbeef, -1);
        push(16'd3, 32'd250, -1);
        push(16'd1, 32'd1, -1);
        push(16'd3, 32'd254, -1);
        push(16'd3, 32'd250, -1);
        push(16'd3, 32'd254, -1);
        push(16'd1, 32'd0, -1);
        do_start();
        begin
            int n = 0;
            while (acc_cnt < 7 && n < 300) begin
                @(negedge wb_clk_i);
                n++;
            end
            @(negedge wb_clk_i);
            while (!bus.m_stb_o && n < 300) begin
                @(negedge wb_clk_i);
                n++;
            end
            chk("t3_reached_8th_write", 64'(bus.m_stb_o), 64'd1);
        end
        abort_i = 1'b1;
        @(negedge wb_clk_i);
        abort_i = 1'b0;
        wait_idle(100);
        chk("t3_done_count", 64'(done_cnt), 64'd1);
        chk("t3_cur_tw", 64'(cur_tw_o), 64'd254);
        chk("t3_err", 64'(err_o), 64'd0);
        chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);

        // zero step holds one tone with a silent bus until abort
        set_cfg(2'd0, 2'd1, 16'h00ff, 8'd77, 8'd100, 8'd0, 16'd3, 1'b0);
        push(16'd2, 32'd0, -1);
        push(16'd4, 32'd1, -1);
        push(16'd5, 32'h00ff, -1);
        push(16'd3, 32'd77, -1);
        push(16'd1, 32'd1, -1);
        do_start();
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 200) begin
                @(negedge wb_clk_i);
                n++;
            end
        end
        chk("t4_setup_drained", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge wb_clk_i);
        stb_cycles = 0;
        repeat (1000) @(negedge wb_clk_i);
        chk("t4_no_bus_traffic", 64'(stb_cycles), 64'd0);
        chk("t4_cur_tw", 64'(cur_tw_o), 64'd77);
        chk("t4_busy", 64'(busy_o), 64'd1);
        push(16'd1, 32'd0, -1);
        pulse_abort();
        wait_idle(50);
        chk("t4_done_count", 64'(done_cnt), 64'd1);
        chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);

        // dead slave: ack timeout
        slave_en = 1'b0;
        set_cfg(2'd1, 2'd1, 16'd1, 8'd5, 8'd6, 8'd1, 16'd1, 1'b0);
        do_start();
        wait_idle(100);
        chk("t5_stb_high_cycles", 64'(stb_cycles), 64'd15);
        chk("t5_err", 64'(err_o), 64'd1);
        chk("t5_done_count", 64'(done_cnt), 64'd1);
        chk("t5_stb_low", 64'(bus.m_stb_o), 64'd0);
        repeat (5) @(negedge wb_clk_i);
        chk("t5_err_sticky", 64'(err_o), 64'd1);
        slave_en = 1'b1;

        // next start clears err; start above stop and dwell 0 behaving as 1
        set_cfg(2'd3, 2'd0, 16'h8000, 8'd200, 8'd100, 8'd1, 16'd0, 1'b0);
        push(16'd2, 32'd3, 1);
        push(16'd4, 32'd0, 4);
        push(16'd5, 32'h8000, 7);
        push(16'd3, 32'd200, 10);
        push(16'd1, 32'd1, 13);
        push(16'd1, 32'd0, 18);
        do_start();
        chk("t5_err_cleared", 64'(err_o), 64'd0);
        wait_idle(100);
        chk("tb_done_cycle", 64'(done_cyc), 64'd20);
        chk("tb_cur_tw", 64'(cur_tw_o), 64'd200);
        chk("tb_queue_empty", 64'(exp_q.size()), 64'd0);

        // async reset in the middle of the first write, then a clean restart
        set_cfg(2'd1, 2'd2, 16'h0042, 8'd9, 8'd9, 8'd3, 16'd1, 1'b0);
        do_start();
        @(negedge wb_clk_i);
        wb_rst_n_i = 1'b0;
        #1;
        chk("t6_rst_stb", 64'(bus.m_stb_o), 64'd0);
        chk("t6_rst_busy", 64'(busy_o), 64'd0);
        chk("t6_rst_addr", 64'(bus.m_addr_o), 64'd0);
        chk("t6_rst_cur_tw", 64'(cur_tw_o), 64'd0);
        chk("t6_rst_err", 64'(err_o), 64'd0);
        @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        push(16'd2, 32'd1, 1);
        push(16'd4, 32'd2, 4);
        push(16'd5, 32'h0042, 7);
        push(16'd3, 32'd9, 10);
        push(16'd1, 32'd1, 13);
        push(16'd1, 32'd0, 18);
        do_start();
        wait_idle(100);
        chk("t6_done_count", 64'(done_cnt), 64'd1);
        chk("t6_cur_tw", 64'(cur_tw_o), 64'd9);
        chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
